nor_test_unit: RTL and testbench
================================

// Module: nor_test_unit
// PURPOSE
//   Registered bitwise NOR unit for the binary-logic step of the datapath.
//   Computes result = ~(a | b) per bit with one cycle of latency, and adds
//   simple status outputs (zero, all-ones, population count) for downstream
//   flag logic. It is a leaf block with one clock and no internal FSM beyond
//   the valid pipeline stage.
// PARAMETERS
//   WIDTH    4   operand and result width in bits (>=1)
//   CNT_W    3   width of popcount output; must hold WIDTH, i.e. clog2(WIDTH+1)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        a/b are valid this cycle
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B
//   out_valid  out  1        result/flags valid this cycle
//   result     out  WIDTH    registered ~(a | b)
//   zero       out  1        result == 0
//   all_ones   out  1        result == all ones
//   ones_cnt   out  CNT_W    number of 1 bits in result
// BEHAVIOUR
//   - Reset: sampled on posedge clk while rst_n==0. Values after reset:
//     out_valid=0, result=0, zero=1, all_ones=0, ones_cnt=0.
//   - Latency: exactly 1 cycle. On the posedge where in_valid==1, register
//     result<=~(a|b) and out_valid<=1. Flags are computed from the new result
//     in the same edge, so all outputs are mutually consistent.
//   - in_valid==0 at a posedge: out_valid<=0; result and flags HOLD their
//     last values (no bubble clearing).
//   - No back-pressure: a new operand may be accepted every cycle; back-to-back
//     valid inputs give back-to-back valid outputs.
//   - Bitwise and width-exact: bit i of result depends only on a[i], b[i].
//     No carries and no sign semantics.
//   - ones_cnt is zero-extended to CNT_W. zero==(ones_cnt==0) and
//     all_ones==(ones_cnt==WIDTH) always hold.
//   - Reset has priority over in_valid on the same edge.
//   - rst_n asserted mid-stream: the in-flight result is discarded and
//     outputs return to their reset values on that edge.
//   - Never produce X on outputs after the first reset edge, even if a/b are
//     X while in_valid==0.
// TESTING
//   1. rst_n=0 for 2 cycles -> out_valid=0, result=0000, zero=1, ones_cnt=0.
//   2. a=0110, b=1001, in_valid=1, one edge -> result=0000, zero=1,
//      all_ones=0, ones_cnt=0, out_valid=1.
//   3. a=0000, b=0000, in_valid=1 -> result=1111, all_ones=1, zero=0,
//      ones_cnt=4.
//   4. a=0101, b=0001 then in_valid=0 for 2 cycles -> result=1010,
//      ones_cnt=2. out_valid is 1 for one cycle, then 0, and result holds
//      at 1010.
//   5. Back-to-back: a/b = 0000/0000, 1111/0000, 0011/0100 on consecutive
//      edges -> results 1111, 0000, 1000, each valid one cycle later.
//   6. rst_n=0 on the same edge as in_valid=1 (a=b=0) -> reset values,
//      out_valid=0. Repeat the exhaustive 256 a/b pairs against the
//      ~(a|b) model.

Source files
------------

// File: rtl/nor_test_unit.sv
// nor_test_unit: registered bitwise NOR with zero, all-ones and popcount status flags
module nor_test_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             all_ones,
    output logic [CNT_W-1:0] ones_cnt
);
    logic [WIDTH-1:0] w_nor;
    logic [CNT_W-1:0] w_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_all_ones;
    logic [CNT_W-1:0] r_cnt;

    assign w_nor     = ~(a | b);
    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign all_ones  = r_all_ones;
    assign ones_cnt  = r_cnt;

    // Popcount of the next result so flags register in the same edge as the data
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            w_cnt = w_cnt + CNT_W'(w_nor[i]);
    end

    // Result and flags load only on valid input and otherwise hold; reset wins over in_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_all_ones <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_nor;
                r_zero     <= ~|w_nor;
                r_all_ones <= &w_nor;
                r_cnt      <= w_cnt;
            end
        end
    end
endmodule

// File: tb/tb_nor_test_unit.sv
// tb_nor_test_unit: directed and exhaustive checks of nor_test_unit against a queued NOR model
module tb_nor_test_unit;
    typedef struct packed {
        logic [3:0] r;
        logic       z;
        logic       ao;
        logic [2:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       out_valid;
    logic [3:0] result;
    logic       zero;
    logic       all_ones;
    logic [2:0] ones_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;

    nor_test_unit #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .zero(zero),
        .all_ones(all_ones), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] n;
        n = ~(x | y);
        return '{r: n, z: (n == 4'h0), ao: (n == 4'hF), c: 3'($countones(n))};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge of stimulus; outputs are compared 1 time unit after the edge
    task automatic step(input string tag, input logic v, input logic [3:0] x,
                        input logic [3:0] y, input logic rn);
        exp_t e;
        @(negedge clk);
        rst_n    = rn;
        in_valid = v;
        a        = x;
        b        = y;
        if (v && rn) sb.push_back(model(x, y));
        @(posedge clk);
        #1;
        if (!rn) begin
            sb.delete();
            held = '{r: 4'h0, z: 1'b1, ao: 1'b0, c: 3'd0};
            chk({tag, "_valid"}, 12'(out_valid), 12'(1'b0));
        end else if (v) begin
            chk({tag, "_valid"}, 12'(out_valid), 12'(1'b1));
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 12'(1), 12'(0));
                return;
            end
            e    = sb.pop_front();
            held = e;
        end else begin
            chk({tag, "_valid"}, 12'(out_valid), 12'(1'b0));
        end
        chk({tag, "_out"}, 12'({result, zero, all_ones, ones_cnt}), 12'(held));
    endtask

    initial begin
        held = '{r: 4'h0, z: 1'b1, ao: 1'b0, c: 3'd0};
        step("rst0", 1'b0, 4'h0, 4'h0, 1'b0);
        step("rst1", 1'b0, 4'h0, 4'h0, 1'b0);
        step("t2", 1'b1, 4'b0110, 4'b1001, 1'b1);
        step("t3", 1'b1, 4'b0000, 4'b0000, 1'b1);
        step("t4", 1'b1, 4'b0101, 4'b0001, 1'b1);
        step("t4_hold0", 1'b0, 4'bxxxx, 4'bxxxx, 1'b1);
        step("t4_hold1", 1'b0, 4'bxxxx, 4'bxxxx, 1'b1);
        chk("t4_result", 12'(result), 12'(4'b1010));
        chk("t4_cnt", 12'(ones_cnt), 12'(3'd2));
        step("t5a", 1'b1, 4'b0000, 4'b0000, 1'b1);
        chk("t5a_result", 12'(result), 12'(4'b1111));
        step("t5b", 1'b1, 4'b1111, 4'b0000, 1'b1);
        chk("t5b_result", 12'(result), 12'(4'b0000));
        step("t5c", 1'b1, 4'b0011, 4'b0100, 1'b1);
        chk("t5c_result", 12'(result), 12'(4'b1000));
        step("t6_rst", 1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 256; i++)
            step("exh", 1'b1, 4'(i >> 4), 4'(i), 1'b1);
        step("end_hold", 1'b0, 4'h0, 4'h0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
